bus_responder: RTL and testbench

- Target side of the CPU memory bus: receives `address`, `read_write`, `data_write` from the cpu top and returns `data_read`.
- Contains:
  - zero-page/stack RAM
  - a reset-vector constant
  - a memory-mapped I/O window with an output port, a synchronized input port and a 16-bit down-counting timer
- Instantiated beside cpu in the system top; sole driver of the CPU's `data_read`.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_responder_if.sv | 13 +
 rtl/bus_timer.sv | 125 ++++++++++++
 rtl/bus_responder.sv | 105 ++++++++++
 tb/tb_bus_responder.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus target: I/O register offsets, CTRL bit
// positions, vector addresses and state encodings. Optional IRQ: TIMER_IRQ_EN.
package bus_pkg;

   localparam logic [2:0] OFS_PORT_OUT = 3'd0;
   localparam logic [2:0] OFS_PORT_IN  = 3'd1;
   localparam logic [2:0] OFS_RELOAD_L = 3'd2;
   localparam logic [2:0] OFS_RELOAD_H = 3'd3;
   localparam logic [2:0] OFS_CTRL     = 3'd4;
   localparam logic [2:0] OFS_STATUS   = 3'd5;
   localparam logic [2:0] OFS_COUNT_L  = 3'd6;
   localparam logic [2:0] OFS_COUNT_H  = 3'd7;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_IE   = 2;

   localparam logic [15:0] VEC_LO = 16'hFFFC;
   localparam logic [15:0] VEC_HI = 16'hFFFD;

   typedef enum logic {T_IDLE = 1'b0, T_RUN = 1'b1} timer_state_t;

   // Which registered source drives data_read
   typedef enum logic {SRC_REG = 1'b0, SRC_RAM = 1'b1} rd_src_t;

endpackage

// File: rtl/bus_responder_if.sv
// CPU memory bus: the CPU (master) drives address/control/write data,
// the responder (slave) returns registered read data.
interface bus_responder_if;

   logic [15:0] address;
   logic        read_write;
   logic [7:0]  data_write;
   logic [7:0]  data_read;

   modport master (output address, output read_write, output data_write, input data_read);
   modport slave  (input address, input read_write, input data_write, output data_read);

endinterface

// File: rtl/bus_timer.sv
// 16-bit down-counting timer with reload, one-shot/auto modes, sticky EXPIRED
// flag and L-then-H atomic count read. Optional IE bit/irq: TIMER_IRQ_EN.
module bus_timer
   import bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_wr_stb,
   input  logic       i_rd_stb,
   input  logic [2:0] i_ofs,
   input  logic [7:0] i_wdata,
`ifdef TIMER_IRQ_EN
   output logic       o_irq,
`endif
   output logic [7:0] o_rdata
);

   timer_state_t r_state, w_state_next;
   logic [15:0]  r_reload, w_reload_next;
   logic [15:0]  r_count, w_count_next;
   logic         r_auto, w_auto_next;
   logic         r_expired, w_expired_next;
   logic [7:0]   r_count_h, w_count_h_next;
   logic         w_expire;
   logic         w_clr;
   logic         w_ie;

`ifdef TIMER_IRQ_EN
   logic r_ie;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ie <= 1'b0;
      end else if (i_wr_stb && i_ofs == OFS_CTRL) begin
         r_ie <= i_wdata[CTRL_IE];
      end
   end

   assign w_ie  = r_ie;
   assign o_irq = r_expired & r_ie;
`else
   assign w_ie = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= T_IDLE;
         r_reload  <= 16'h0000;
         r_count   <= 16'h0000;
         r_auto    <= 1'b0;
         r_expired <= 1'b0;
         r_count_h <= 8'h00;
      end else begin
         r_state   <= w_state_next;
         r_reload  <= w_reload_next;
         r_count   <= w_count_next;
         r_auto    <= w_auto_next;
         r_expired <= w_expired_next;
         r_count_h <= w_count_h_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_reload_next  = r_reload;
      w_count_next   = r_count;
      w_auto_next    = r_auto;
      w_count_h_next = r_count_h;
      w_expire       = 1'b0;

      // Zero is tested before decrementing, so the count never wraps
      if (r_state == T_RUN) begin
         if (r_count == 16'h0000) begin
            w_expire = 1'b1;
            if (r_auto) begin
               w_count_next = r_reload;
            end else begin
               w_state_next = T_IDLE;
            end
         end else begin
            w_count_next = r_count - 16'd1;
         end
      end

      if (i_wr_stb) begin
         case (i_ofs)
            OFS_RELOAD_L: w_reload_next[7:0]  = i_wdata;
            OFS_RELOAD_H: w_reload_next[15:8] = i_wdata;
            OFS_CTRL: begin
               w_auto_next = i_wdata[CTRL_AUTO];
               if (!i_wdata[CTRL_EN]) begin
                  w_state_next = T_IDLE;
                  w_count_next = r_count;
               end else if (r_state == T_IDLE) begin
                  w_state_next = T_RUN;
                  w_count_next = r_reload;
               end
            end
            default: ;
         endcase
      end

      if (i_rd_stb && i_ofs == OFS_COUNT_L) begin
         w_count_h_next = r_count[15:8];
      end

      // A coinciding expiry beats a read- or write-clear
      w_clr = (i_ofs == OFS_STATUS) && (i_rd_stb || (i_wr_stb && i_wdata[0]));
      w_expired_next = w_expire | (r_expired & ~w_clr);
   end

   always_comb begin
      o_rdata = 8'h00;
      case (i_ofs)
         OFS_RELOAD_L: o_rdata = r_reload[7:0];
         OFS_RELOAD_H: o_rdata = r_reload[15:8];
         OFS_CTRL:     o_rdata = {5'b00000, w_ie, r_auto, r_state == T_RUN};
         OFS_STATUS:   o_rdata = {7'b0000000, r_expired};
         OFS_COUNT_L:  o_rdata = r_count[7:0];
         OFS_COUNT_H:  o_rdata = r_count_h;
         default:      o_rdata = 8'h00;
      endcase
   end

endmodule

// File: rtl/bus_responder.sv
// Bus target beside the CPU: RAM, reset vector, I/O window (port out, synced
// port in, timer). Optional timer interrupt output: TIMER_IRQ_EN.
module bus_responder
   import bus_pkg::*;
#(
   parameter int          RAM_AW        = 10,
   parameter logic [15:0] IO_BASE       = 16'hD000,
   parameter logic [15:0] RESET_VEC     = 16'h0200,
   parameter logic [7:0]  UNMAPPED_DATA = 8'hEA
)
(
   input  logic             clk,
   input  logic             rst,
   bus_responder_if.slave   bus,
   input  logic [7:0]       port_in,
`ifdef TIMER_IRQ_EN
   output logic             irq,
`endif
   output logic [7:0]       port_out
);

   logic [7:0]        r_ram [0:(1 << RAM_AW) - 1];
   logic [7:0]        r_ram_q;
   logic [7:0]        r_reg_q;
   rd_src_t           r_src;
   logic [7:0]        r_port_out;
   logic [7:0]        r_sync1, r_sync2;

   logic              w_ram_sel;
   logic              w_io_sel;
   logic [RAM_AW-1:0] w_ram_idx;
   logic [2:0]        w_ofs;
   logic [7:0]        w_reg_data;
   logic [7:0]        w_tmr_rdata;
   logic              w_io_wr, w_io_rd;

   assign w_ram_sel = (bus.address >> RAM_AW) == 16'h0000;
   assign w_io_sel  = (bus.address[15:3] == IO_BASE[15:3]) && !w_ram_sel;
   assign w_ram_idx = bus.address[RAM_AW-1:0];
   assign w_ofs     = bus.address[2:0];
   assign w_io_wr   = w_io_sel && !bus.read_write;
   assign w_io_rd   = w_io_sel && bus.read_write;

   // Plain registered-read array so it maps onto block RAM; no reset
   always_ff @(posedge clk) begin
      if (!bus.read_write && w_ram_sel) begin
         r_ram[w_ram_idx] <= bus.data_write;
      end
      if (bus.read_write) begin
         r_ram_q <= r_ram[w_ram_idx];
      end
   end

   bus_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_wr_stb (w_io_wr),
      .i_rd_stb (w_io_rd),
      .i_ofs    (w_ofs),
      .i_wdata  (bus.data_write),
`ifdef TIMER_IRQ_EN
      .o_irq    (irq),
`endif
      .o_rdata  (w_tmr_rdata)
   );

   always_comb begin
      w_reg_data = UNMAPPED_DATA;
      if (w_io_sel) begin
         case (w_ofs)
            OFS_PORT_OUT: w_reg_data = r_port_out;
            OFS_PORT_IN:  w_reg_data = r_sync2;
            default:      w_reg_data = w_tmr_rdata;
         endcase
      end else if (bus.address == VEC_LO) begin
         w_reg_data = RESET_VEC[7:0];
      end else if (bus.address == VEC_HI) begin
         w_reg_data = RESET_VEC[15:8];
      end
   end

   // Reset selects the zeroed register path so stale RAM output never leaks
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_src      <= SRC_REG;
         r_reg_q    <= 8'h00;
         r_port_out <= 8'h00;
         r_sync1    <= 8'h00;
         r_sync2    <= 8'h00;
      end else begin
         r_sync1 <= port_in;
         r_sync2 <= r_sync1;
         if (bus.read_write) begin
            r_src   <= w_ram_sel ? SRC_RAM : SRC_REG;
            r_reg_q <= w_reg_data;
         end else if (w_io_sel && w_ofs == OFS_PORT_OUT) begin
            r_port_out <= bus.data_write;
         end
      end
   end

   assign bus.data_read = (r_src == SRC_RAM) ? r_ram_q : r_reg_q;
   assign port_out      = r_port_out;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: one bus cycle per step, expected values
// hand-computed; IRQ checks compiled only with TIMER_IRQ_EN.
module tb_bus_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] port_in;
   logic [7:0] port_out;
`ifdef TIMER_IRQ_EN
   logic       irq;
`endif
   int         tests = 0;
   int         fails = 0;

   bus_responder_if bus_if ();

   bus_responder dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if),
      .port_in  (port_in),
`ifdef TIMER_IRQ_EN
      .irq      (irq),
`endif
      .port_out (port_out)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic [15:0] a, input logic rw, input logic [7:0] d);
      bus_if.address    = a;
      bus_if.read_write = rw;
      bus_if.data_write = d;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [15:0] a);
      cyc(a, 1'b1, 8'h00);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      cyc(a, 1'b0, d);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
      $display("[TB] %-14s observed %02h expected %02h", tag, obs, exp);
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
      rd(a);
      chk(tag, bus_if.data_read, exp);
   endtask

   initial begin
      logic [7:0] auto_exp [6];
      auto_exp = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};

      rst     = 1'b0;
      port_in = 8'h00;
      rd(16'h0400);
      rd(16'h0400);
      chk("rst_data_read", bus_if.data_read, 8'h00);
      chk("rst_port_out", port_out, 8'h00);
      rst = 1'b1;

      rd_chk("vec_lo", 16'hFFFC, 8'h00);
      rd_chk("vec_hi", 16'hFFFD, 8'h02);
      rd_chk("port_out_rst", 16'hD000, 8'h00);

      // RAM, unmapped, hold on write
      wr(16'h01FF, 8'hA5);
      rd_chk("ram_01ff", 16'h01FF, 8'hA5);
      rd_chk("unmapped_0400", 16'h0400, 8'hEA);
      wr(16'h0010, 8'h11);
      chk("hold_on_write", bus_if.data_read, 8'hEA);
      rd_chk("ram_0010", 16'h0010, 8'h11);
      wr(16'h03FF, 8'h77);
      rd_chk("ram_top", 16'h03FF, 8'h77);

      wr(16'hD000, 8'h3C);
      chk("port_out_pin", port_out, 8'h3C);
      rd_chk("port_out_rd", 16'hD000, 8'h3C);

      // One-shot, reload 3: expiry at the 4th edge after the CTRL write
      wr(16'hD002, 8'h03);
      wr(16'hD003, 8'h00);
      wr(16'hD004, 8'h01);
      for (int i = 1; i <= 4; i++) rd_chk("oneshot_pre", 16'hD005, 8'h00);
      rd_chk("oneshot_exp", 16'hD005, 8'h01);
      rd_chk("oneshot_ctrl", 16'hD004, 8'h00);
      rd_chk("oneshot_cnt_l", 16'hD006, 8'h00);
      rd_chk("oneshot_cnt_h", 16'hD007, 8'h00);

      // Auto-reload 1: expiries every 2nd edge, reads race set/clear
      wr(16'hD002, 8'h01);
      wr(16'hD004, 8'h03);
      for (int i = 0; i < 6; i++) rd_chk("auto_status", 16'hD005, auto_exp[i]);
      wr(16'hD004, 8'h00);
      rd_chk("auto_sticky", 16'hD005, 8'h01);
      rd_chk("auto_cleared", 16'hD005, 8'h00);

      // Atomic count, reload 0x0100
      wr(16'hD002, 8'h00);
      wr(16'hD003, 8'h01);
      wr(16'hD004, 8'h03);
      rd_chk("atom_l0", 16'hD006, 8'h00);
      rd(16'h0400);
      rd(16'h0400);
      rd_chk("atom_h0", 16'hD007, 8'h01);
      rd_chk("atom_l1", 16'hD006, 8'hFC);
      rd_chk("atom_h1", 16'hD007, 8'h00);
      wr(16'hD004, 8'h00);

      // Input synchronizer: two flops plus the read register
      port_in = 8'h5A;
      rd_chk("port_in_e1", 16'hD001, 8'h00);
      rd_chk("port_in_e2", 16'hD001, 8'h00);
      rd_chk("port_in_e3", 16'hD001, 8'h5A);

      // One-shot reload 2 with IE requested
      wr(16'hD002, 8'h02);
      wr(16'hD003, 8'h00);
      wr(16'hD004, 8'h05);
      rd_chk("ie_status_c1", 16'hD005, 8'h00);
      rd_chk("ie_status_c2", 16'hD005, 8'h00);
`ifdef TIMER_IRQ_EN
      chk("irq_low", {7'b0, irq}, 8'h00);
      rd_chk("ie_ctrl_run", 16'hD004, 8'h05);
      chk("irq_rise", {7'b0, irq}, 8'h01);
      rd_chk("ie_ctrl_idle", 16'hD004, 8'h04);
      rd_chk("ie_status", 16'hD005, 8'h01);
      chk("irq_fall", {7'b0, irq}, 8'h00);
`else
      rd_chk("ie_ctrl_run", 16'hD004, 8'h01);
      rd_chk("ie_ctrl_idle", 16'hD004, 8'h00);
      rd_chk("ie_status", 16'hD005, 8'h01);
`endif

      // Reset while counting
      wr(16'hD002, 8'h10);
      wr(16'hD004, 8'h01);
      rd_chk("pre_reset", 16'hFFFD, 8'h02);
      rst = 1'b0;
      rd(16'hFFFD);
      chk("mid_rst_data", bus_if.data_read, 8'h00);
      chk("mid_rst_port", port_out, 8'h00);
      rst = 1'b1;
      rd_chk("post_rst_ctrl", 16'hD004, 8'h00);
      rd_chk("post_rst_cnt", 16'hD006, 8'h00);
      rd_chk("post_rst_rld", 16'hD002, 8'h00);
      rd_chk("post_rst_ram", 16'h01FF, 8'hA5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
